// File: rtl/latch_edge_monitor.sv
// Synchronizes and debounces an asynchronous latch output, emits edge pulses,
// counts edges and queues edge events; define LATCH_MON_TIMESTAMP_EN to timestamp events.
module latch_edge_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  output logic             q_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W:0]   evt_data,
  output logic             overflow
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_e;

  state_e                 state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rise_pulse_q, rise_pulse_d;
  logic                   fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0]       rise_count_q, rise_count_d;
  logic [CNT_W-1:0]       fall_count_q, fall_count_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            fifo_cnt_q, fifo_cnt_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W:0]         mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]       ts_now;
  logic                   s;
  logic                   push_req, push, pop, fifo_full;

`ifdef LATCH_MON_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign ts_now = ts_q;
`else
  assign ts_now = '0;
`endif

  // Only the last synchronizer stage may be observed by the debounce logic.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], q_in};
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    rise_pulse_d = 1'b0;
    fall_pulse_d = 1'b0;
    case (state_q)
      STABLE_LO: if (s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_d      = STABLE_HI;
          rise_pulse_d = 1'b1;
        end else begin
          state_d  = PEND_HI;
          db_cnt_d = DB_W'(1);
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d  = STABLE_LO;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = STABLE_HI;
          db_cnt_d     = '0;
          rise_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      STABLE_HI: if (!s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_d      = STABLE_LO;
          fall_pulse_d = 1'b1;
        end else begin
          state_d  = PEND_LO;
          db_cnt_d = DB_W'(1);
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d  = STABLE_HI;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = STABLE_LO;
          db_cnt_d     = '0;
          fall_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = STABLE_LO;
        db_cnt_d = '0;
      end
    endcase
  end

  // Counters move with the state change so they appear together with the pulse.
  always_comb begin
    rise_count_d = rise_count_q;
    fall_count_d = fall_count_q;
    if (clr) begin
      rise_count_d = '0;
      fall_count_d = '0;
    end else begin
      if (rise_pulse_d) rise_count_d = rise_count_q + CNT_W'(1);
      if (fall_pulse_d) fall_count_d = fall_count_q + CNT_W'(1);
    end
  end

  assign fifo_full = (fifo_cnt_q == FIFO_FULL);
  assign evt_valid = (fifo_cnt_q != '0);
  assign push_req  = (rise_pulse_q | fall_pulse_q) & ~clr;
  assign pop       = evt_valid & evt_ready & ~clr;
  assign push      = push_req & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
      if (push_req && !push) overflow_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STABLE_LO;
      db_cnt_q     <= '0;
      sync_q       <= '0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      rise_count_q <= '0;
      fall_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      sync_q       <= sync_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      rise_count_q <= rise_count_d;
      fall_count_q <= fall_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: the event storage has no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {rise_pulse_q, ts_now};
  end

  assign q_stable   = (state_q == STABLE_HI) || (state_q == PEND_LO);
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign rise_count = rise_count_q;
  assign fall_count = fall_count_q;
  assign evt_data   = mem_q[rd_ptr_q];
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_latch_edge_monitor.sv
// Self-checking bench for latch_edge_monitor: directed scenarios plus a randomized run
// against a sliding-window debounce model and a queue-based event FIFO model.
module tb_latch_edge_monitor;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
`ifdef LATCH_MON_TIMESTAMP_EN
  localparam logic [CW-1:0] FIRST_TS = 8'd7;
`else
  localparam logic [CW-1:0] FIRST_TS = 8'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          q_in = 1'b0;
  logic          clr = 1'b0;
  logic          evt_ready = 1'b0;
  logic          q_stable, rise_pulse, fall_pulse, evt_valid, overflow;
  logic [CW-1:0] rise_count, fall_count;
  logic [CW:0]   evt_data;

  int tests_run    = 0;
  int tests_failed = 0;

  latch_edge_monitor #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr),
    .q_stable(q_stable), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .rise_count(rise_count), .fall_count(fall_count),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a level is accepted once the last DEB synchronized samples
  // all disagree with the current accepted level.
  bit            m_dl[$];
  bit            m_win[$];
  bit            m_stable, m_rise, m_fall, m_ovf;
  int unsigned   m_rc, m_fc, m_ts;
  logic [CW:0]   m_fifo[$];

  task automatic model_step(input bit q, input bit c, input bit r, input bit rs);
    bit            s, flip;
    logic [CW-1:0] ts_bits;
    if (rs) begin
      m_dl.delete();
      m_win.delete();
      for (int i = 0; i < SYNC; i++) m_dl.push_back(1'b0);
      for (int i = 0; i < DEB; i++) m_win.push_back(1'b0);
      m_stable = 0; m_rise = 0; m_fall = 0; m_ovf = 0;
      m_rc = 0; m_fc = 0; m_ts = 0;
      m_fifo.delete();
      return;
    end
    s = m_dl.pop_front();
    m_dl.push_back(q);
    void'(m_win.pop_front());
    m_win.push_back(s);
    flip = 1'b1;
    foreach (m_win[i]) if (m_win[i] == m_stable) flip = 1'b0;
    ts_bits = CW'(m_ts);
`ifndef LATCH_MON_TIMESTAMP_EN
    ts_bits = '0;
`endif
    if (c) begin
      m_fifo.delete();
      m_ovf = 0;
      m_rc = 0;
      m_fc = 0;
    end else begin
      if (m_fifo.size() > 0 && r) void'(m_fifo.pop_front());
      if (m_rise || m_fall) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back({m_rise, ts_bits});
        else m_ovf = 1;
      end
      if (flip && !m_stable) m_rc = (m_rc + 1) % (1 << CW);
      if (flip && m_stable)  m_fc = (m_fc + 1) % (1 << CW);
    end
    m_rise = flip && !m_stable;
    m_fall = flip && m_stable;
    if (flip) m_stable = !m_stable;
    m_ts = (m_ts + 1) % (1 << CW);
  endtask

  task automatic tick(input bit q, input bit c, input bit r, input bit rs);
    q_in = q; clr = c; evt_ready = r; rst = rs;
    @(posedge clk);
    model_step(q, c, r, rs);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Hold a level long enough for it to be accepted and its event pushed.
  task automatic make_edge(input bit q, input bit r);
    for (int i = 0; i < 9; i++) tick(q, 1'b0, r, 1'b0);
  endtask

  // Drive a level until a pulse is observed; returns inside the pulse cycle.
  task automatic wait_pulse(input bit q, input bit r, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(q, 1'b0, r, 1'b0);
      if (rise_pulse || fall_pulse) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
    tests_run++; if (q_stable !== 1'b0) begin tests_failed++; $display("FAIL reset_q_stable got=%0b exp=0", q_stable); end
    tests_run++; if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses got=%0b%0b exp=00", rise_pulse, fall_pulse); end
    tests_run++; if (rise_count !== '0 || fall_count !== '0) begin tests_failed++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", rise_count, fall_count); end
    tests_run++; if (evt_valid !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo got valid=%0b ovf=%0b exp=0/0", evt_valid, overflow); end
  endtask

  task automatic test_first_rise();
    bit early;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    early = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (rise_pulse !== 1'b0 || q_stable !== 1'b0) early = 1'b1;
    end
    tests_run++; if (early) begin tests_failed++; $display("FAIL first_rise_early got=early exp=none"); end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++; if (rise_pulse !== 1'b1 || q_stable !== 1'b1) begin tests_failed++; $display("FAIL first_rise_edge got pulse=%0b stable=%0b exp=1/1", rise_pulse, q_stable); end
    tests_run++; if (rise_count !== 8'd1) begin tests_failed++; $display("FAIL first_rise_count got=%0d exp=1", rise_count); end
    tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL first_rise_valid_early got=%0b exp=0", evt_valid); end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++; if (rise_pulse !== 1'b0) begin tests_failed++; $display("FAIL first_rise_pulse_width got=%0b exp=0", rise_pulse); end
    tests_run++; if (evt_valid !== 1'b1 || evt_data !== {1'b1, FIRST_TS}) begin tests_failed++; $display("FAIL first_rise_event got valid=%0b data=%h exp=1/%h", evt_valid, evt_data, {1'b1, FIRST_TS}); end
  endtask

  task automatic test_glitch();
    bit any_pulse;
    do_reset();
    any_pulse = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin tick(1'b1, 1'b0, 1'b0, 1'b0); any_pulse |= rise_pulse | fall_pulse; end
    for (int i = 0; i < 12; i++) begin tick(1'b0, 1'b0, 1'b0, 1'b0); any_pulse |= rise_pulse | fall_pulse; end
    tests_run++; if (any_pulse) begin tests_failed++; $display("FAIL glitch_pulse got=pulse exp=none"); end
    tests_run++; if (rise_count !== '0 || fall_count !== '0 || evt_valid !== 1'b0 || q_stable !== 1'b0) begin tests_failed++; $display("FAIL glitch_state got rc=%0d fc=%0d valid=%0b stable=%0b exp=0/0/0/0", rise_count, fall_count, evt_valid, q_stable); end
  endtask

  task automatic test_overflow();
    bit exp_bit;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) make_edge(i % 2 == 0, 1'b0);
    tests_run++; if (overflow !== 1'b1 || evt_valid !== 1'b1) begin tests_failed++; $display("FAIL overflow_flag got ovf=%0b valid=%0b exp=1/1", overflow, evt_valid); end
    tests_run++; if (rise_count !== 8'd3 || fall_count !== 8'd2) begin tests_failed++; $display("FAIL overflow_counts got=%0d/%0d exp=3/2", rise_count, fall_count); end
    for (int i = 0; i < 4; i++) begin
      exp_bit = (i % 2 == 0);
      tests_run++; if (evt_valid !== 1'b1 || evt_data[CW] !== exp_bit) begin tests_failed++; $display("FAIL drain_order[%0d] got valid=%0b type=%0b exp=1/%0b", i, evt_valid, evt_data[CW], exp_bit); end
      tests_run++; if (evt_data !== m_fifo[0]) begin tests_failed++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, evt_data, m_fifo[0]); end
      tick(1'b1, 1'b0, 1'b1, 1'b0);
    end
    tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_full_pop();
    bit       seen;
    int       n;
    bit [3:0] got;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) make_edge(i % 2 == 0, 1'b0);
    wait_pulse(1'b1, 1'b0, seen);
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL full_pop_pulse got=timeout exp=pulse"); end
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++; if (overflow !== 1'b0 || evt_valid !== 1'b1) begin tests_failed++; $display("FAIL full_pop_flags got ovf=%0b valid=%0b exp=0/1", overflow, evt_valid); end
    tests_run++; if (evt_data !== m_fifo[0]) begin tests_failed++; $display("FAIL full_pop_head got=%h exp=%h", evt_data, m_fifo[0]); end
    n = 0; got = '0;
    while (evt_valid && n < 8) begin
      if (n < 4) got[n] = evt_data[CW];
      n++;
      tick(1'b1, 1'b0, 1'b1, 1'b0);
    end
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL full_pop_occupancy got=%0d exp=4", n); end
    tests_run++; if (got !== 4'b1010) begin tests_failed++; $display("FAIL full_pop_order got=%b exp=1010", got); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      make_edge(1'b1, 1'b1);
      if (i < 255) make_edge(1'b0, 1'b1);
    end
    tests_run++; if (rise_count !== 8'd0 || fall_count !== 8'd255) begin tests_failed++; $display("FAIL wrap_counts got=%0d/%0d exp=0/255", rise_count, fall_count); end
    tests_run++; if (q_stable !== 1'b1 || overflow !== 1'b0) begin tests_failed++; $display("FAIL wrap_state got stable=%0b ovf=%0b exp=1/0", q_stable, overflow); end
  endtask

  task automatic test_clr();
    bit seen;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) make_edge(i % 2 == 0, 1'b0);
    wait_pulse(1'b0, 1'b0, seen);
    tests_run++; if (!seen || fall_pulse !== 1'b1) begin tests_failed++; $display("FAIL clr_fall_pulse got=%0b exp=1", fall_pulse); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++; if (fall_count !== '0 || rise_count !== '0) begin tests_failed++; $display("FAIL clr_counts got=%0d/%0d exp=0/0", rise_count, fall_count); end
    tests_run++; if (evt_valid !== 1'b0 || overflow !== 1'b0 || q_stable !== 1'b0) begin tests_failed++; $display("FAIL clr_state got valid=%0b ovf=%0b stable=%0b exp=0/0/0", evt_valid, overflow, q_stable); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_discard got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_rst_pend();
    bit any_rise;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tests_run++; if (q_stable !== 1'b0 || rise_pulse !== 1'b0 || rise_count !== '0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL rst_pend_outputs got stable=%0b pulse=%0b rc=%0d valid=%0b ovf=%0b exp=0", q_stable, rise_pulse, rise_count, evt_valid, overflow);
    end
    any_rise = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(1'b0, 1'b0, 1'b0, 1'b0); any_rise |= rise_pulse | q_stable; end
    tests_run++; if (any_rise) begin tests_failed++; $display("FAIL rst_pend_resume got=rise exp=none"); end
  endtask

  task automatic test_random();
    bit q, c, r, rs;
    int hold;
    int shown;
    do_reset();
    q = 0; hold = 0; shown = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin q = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 10); end
      hold--;
      c  = ($urandom_range(0, 63) == 0);
      r  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 999) == 0);
      tick(q, c, r, rs);
      tests_run++;
      if (q_stable !== m_stable || rise_pulse !== m_rise || fall_pulse !== m_fall ||
          rise_count !== CW'(m_rc) || fall_count !== CW'(m_fc) || overflow !== m_ovf ||
          evt_valid !== (m_fifo.size() > 0) || (m_fifo.size() > 0 && evt_data !== m_fifo[0])) begin
        tests_failed++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random[%0d] got st=%0b r=%0b f=%0b rc=%0d fc=%0d ov=%0b v=%0b d=%h exp st=%0b r=%0b f=%0b rc=%0d fc=%0d ov=%0b v=%0b",
                   i, q_stable, rise_pulse, fall_pulse, rise_count, fall_count, overflow, evt_valid, evt_data,
                   m_stable, m_rise, m_fall, m_rc, m_fc, m_ovf, m_fifo.size() > 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_rise();
    test_glitch();
    test_overflow();
    test_full_pop();
    test_clr();
    test_rst_pend();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
